// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, Nk/Nr lookup and the
// GF(2^8) doubling used for rcon generation and the S-box.
package aes_pkg;

  localparam logic [1:0] KEY_128  = 2'b00;
  localparam logic [1:0] KEY_192  = 2'b01;
  localparam logic [1:0] KEY_256  = 2'b10;
  localparam logic [1:0] KEY_RSVD = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_128: nk_of = 4'd4;
      KEY_192: nk_of = 4'd6;
      default: nk_of = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_128: nr_of = 4'd10;
      KEY_192: nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Four-lane SubWord: one S-box per byte of the 32-bit word.
module aes_subword (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sbox u_sbox (
      .x (word[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int n = 0; n < 8; n++) begin
      p = b[n] ? (p ^ t) : p;
      t = xtime(t);
    end
    gf_mul = p;
  endfunction

  // a^254 is the inverse of a (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int n = 0; n < 7; n++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    gf_inv = r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    affine = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign y = affine(gf_inv(x));

endmodule

// File: rtl/aes_key_expand.sv
// FIPS-197 key schedule producing one word per cycle and streaming
// 128-bit round keys over a valid/ready interface.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter logic [2:0] MODE_MASK = 3'b111,
  parameter int         OUT_REG   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         start_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GEN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_r;
  logic [3:0]  nk_r, nr_r;
  logic [5:0]  cnt_r;
  logic [2:0]  pos_r;
  logic [7:0]  rcon_r;
  logic [31:0] win_r [0:7];
  logic [95:0] asm_r;
  logic        valid_r, last_r, err_r;
  logic [3:0]  idx_r;

  logic        supported_s, first_s, out_free_s, adv_s, load_s, final_s;
  logic [3:0]  nk_in_s;
  logic [2:0]  sel_s;
  logic [31:0] kw_s [0:7];
  logic [31:0] win_init_s [0:7];
  logic [31:0] prev_s, old_s, sub_in_s, sub_s, new_word_s;

  // Key-length acceptance against the enabled modes
  always_comb begin
    case (key_len)
      KEY_128: supported_s = MODE_MASK[0];
      KEY_192: supported_s = MODE_MASK[1];
      KEY_256: supported_s = MODE_MASK[2];
      default: supported_s = 1'b0;
    endcase
  end

  assign nk_in_s = nk_of(key_len);

  // Window preload: oldest slot holds key word 0 so the first Nk shifts emit the key
  always_comb begin
    sel_s = 3'd0;
    for (int j = 0; j < 8; j++) begin
      kw_s[j] = key[255 - 32*j -: 32];
    end
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nk_in_s) begin
        sel_s         = 3'(nk_in_s - 4'd1 - 4'(k));
        win_init_s[k] = kw_s[sel_s];
      end else begin
        win_init_s[k] = 32'h0;
      end
    end
  end

  assign prev_s   = win_r[0];
  assign first_s  = cnt_r < {2'b00, nk_r};
  assign sub_in_s = (pos_r == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;

  aes_subword u_subword (
    .word (sub_in_s),
    .sub  (sub_s)
  );

  // Next schedule word from w[i-Nk] and w[i-1]
  always_comb begin
    case (nk_r)
      4'd4:    old_s = win_r[3];
      4'd6:    old_s = win_r[5];
      default: old_s = win_r[7];
    endcase
    if (first_s) begin
      new_word_s = old_s;
    end else if (pos_r == 3'd0) begin
      new_word_s = old_s ^ sub_s ^ {rcon_r, 24'h0};
    end else if (nk_r == 4'd8 && pos_r == 3'd4) begin
      new_word_s = old_s ^ sub_s;
    end else begin
      new_word_s = old_s ^ prev_s;
    end
  end

  // Without an output register the assembly buffer is the output, so every word waits
  assign out_free_s = !valid_r || rk_ready;
  assign adv_s      = (state_r == ST_GEN)
                      && (((OUT_REG != 0) && (cnt_r[1:0] != 2'd3)) || out_free_s);
  assign load_s     = adv_s && (cnt_r[1:0] == 2'd3);
  assign final_s    = adv_s && (cnt_r == {nr_r, 2'b11});

  // Control FSM, word counter, rcon and sliding window
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      nk_r    <= 4'd4;
      nr_r    <= 4'd10;
      cnt_r   <= 6'd0;
      pos_r   <= 3'd0;
      rcon_r  <= RCON_INIT;
      err_r   <= 1'b0;
      for (int k = 0; k < 8; k++) win_r[k] <= 32'h0;
    end else begin
      err_r <= start && (state_r == ST_IDLE) && !supported_s;
      case (state_r)
        ST_IDLE: begin
          if (start && supported_s) begin
            state_r <= ST_GEN;
            nk_r    <= nk_in_s;
            nr_r    <= nr_of(key_len);
            cnt_r   <= 6'd0;
            pos_r   <= 3'd0;
            rcon_r  <= RCON_INIT;
            for (int k = 0; k < 8; k++) win_r[k] <= win_init_s[k];
          end
        end
        ST_GEN: begin
          if (adv_s) begin
            win_r[0] <= new_word_s;
            for (int k = 1; k < 8; k++) win_r[k] <= win_r[k-1];
            cnt_r <= cnt_r + 6'd1;
            pos_r <= ({1'b0, pos_r} == nk_r - 4'd1) ? 3'd0 : pos_r + 3'd1;
            if (!first_s && pos_r == 3'd0) rcon_r <= xtime(rcon_r);
            if (final_s) state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (valid_r && rk_ready && last_r) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Assembly of the first three words of the current round key
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r <= 96'h0;
    end else if (adv_s) begin
      case (cnt_r[1:0])
        2'd0:    asm_r[95:64] <= new_word_s;
        2'd1:    asm_r[63:32] <= new_word_s;
        2'd2:    asm_r[31:0]  <= new_word_s;
        default: asm_r        <= asm_r;
      endcase
    end
  end

  // Round-key handshake state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      idx_r   <= 4'd0;
      last_r  <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      idx_r   <= cnt_r[5:2];
      last_r  <= (cnt_r[5:2] == nr_r);
    end else if (valid_r && rk_ready) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [127:0] data_r;
    // Full round key captured when its last word completes
    always_ff @(posedge clk) begin
      if (rst) begin
        data_r <= 128'h0;
      end else if (load_s) begin
        data_r <= {asm_r, new_word_s};
      end
    end
    assign rk_data = data_r;
  end else begin : g_out_direct
    logic [31:0] tail_r;
    // Last word of the round key alongside the assembly buffer
    always_ff @(posedge clk) begin
      if (rst) begin
        tail_r <= 32'h0;
      end else if (load_s) begin
        tail_r <= new_word_s;
      end
    end
    assign rk_data = {asm_r, tail_r};
  end

  assign start_ready = (state_r == ST_IDLE);
  assign rk_valid    = valid_r;
  assign rk_idx      = idx_r;
  assign rk_last     = last_r;
  assign err         = err_r;

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised bench for aes_key_expand against a textbook key-schedule model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         start_ready, rk_valid, rk_last, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  logic         start2;
  logic [1:0]   key_len2;
  logic         start_ready2, rk_valid2, rk_last2, err2;
  logic [127:0] rk_data2;
  logic [3:0]   rk_idx2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] exp_keys [0:14];

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .key_len(key_len), .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last), .err(err)
  );

  aes_key_expand #(.MODE_MASK(3'b101)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .start_ready(start_ready2),
    .key_len(key_len2), .key(key), .rk_valid(rk_valid2), .rk_ready(rk_ready),
    .rk_data(rk_data2), .rk_idx(rk_idx2), .rk_last(rk_last2), .err(err2)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  // S-box table by brute-force inverse search and the bitwise affine formula
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] k);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr = nk + 6;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          repeat (i/nk - 1) rc = xt(rc);
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Called at a negedge; starts an expansion and checks every delivered round key
  task automatic run_key(input logic [1:0] len, input logic [255:0] k, input bit rand_rdy,
                         input bit poke, input int abort_at, input int kn_idx,
                         input logic [127:0] kn_val);
    int nk, nr, n, got, last_hs;
    bit held, seen;
    logic [127:0] h_data;
    logic [3:0]   h_idx;
    logic         h_last;
    nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
    nr = nk + 6;
    model_expand(nk, k);
    check_eq("start_ready", start_ready, 1);
    start = 1'b1; key_len = len; key = k; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; key = ~k;
    n = 0; got = 0; last_hs = 0; held = 0; seen = 0;
    while (got <= nr && n < 400) begin
      if (poke && n == 2) begin
        start = 1'b1; key_len = 2'b00;
      end else begin
        start = 1'b0;
      end
      if (poke && n == 3) check_eq("busy_no_err", err, 0);
      if (held) begin
        check_eq("hold_valid", rk_valid, 1);
        check_eq("hold_data", rk_data, h_data);
        check_eq("hold_idx", rk_idx, h_idx);
        check_eq("hold_last", rk_last, h_last);
      end
      if (rk_valid && !seen) begin
        check_eq("latency", n, 4);
        seen = 1;
      end
      rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 0;
      if (rk_valid && rk_ready) begin
        check_eq("rk_data", rk_data, exp_keys[got]);
        check_eq("rk_idx", rk_idx, got);
        check_eq("rk_last", rk_last, got == nr);
        if (got == kn_idx) check_eq("known_vector", rk_data, kn_val);
        if (!rand_rdy && got > 0) check_eq("spacing", n - last_hs, 4);
        last_hs = n;
        got++;
      end else if (rk_valid) begin
        held = 1; h_data = rk_data; h_idx = rk_idx; h_last = rk_last;
      end
      @(negedge clk);
      n++;
      if (abort_at >= 0 && got > abort_at) break;
    end
    start = 1'b0;
    rk_ready = 1'b1;
    if (abort_at < 0) begin
      check_eq("key_count", got, nr + 1);
      check_eq("idle_after_last", start_ready, 1);
      check_eq("valid_after_last", rk_valid, 0);
    end
  endtask

  initial begin
    logic [255:0] k;
    build_sbox();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; key_len = 2'b00; key_len2 = 2'b00;
    key = 256'h0; rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_start_ready", start_ready, 1);
    check_eq("rst_rk_valid", rk_valid, 0);
    check_eq("rst_rk_data", rk_data, 0);
    check_eq("rst_rk_idx", rk_idx, 0);
    check_eq("rst_rk_last", rk_last, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_start_ready2", start_ready2, 1);
    rst = 1'b0;

    run_key(2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0, 0, -1,
            10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    run_key(2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 0, 1, -1,
            12, 128'ha4970a331a78dc09c418c271e3a41d5d);
    run_key(2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            1, 0, -1, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    for (int t = 0; t < 6; t++) begin
      k = rand_key();
      run_key(2'(t % 3), k, 1'($urandom_range(0, 1)), 0, -1, -1, 128'h0);
    end

    start = 1'b1; key_len = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check_eq("rsvd_err", err, 1);
    check_eq("rsvd_start_ready", start_ready, 1);
    @(negedge clk);
    check_eq("rsvd_err_pulse", err, 0);
    check_eq("rsvd_no_valid", rk_valid, 0);

    start2 = 1'b1; key_len2 = 2'b01;
    @(negedge clk);
    start2 = 1'b0;
    check_eq("mask_err", err2, 1);
    check_eq("mask_start_ready", start_ready2, 1);
    repeat (6) @(negedge clk);
    check_eq("mask_no_valid", rk_valid2, 0);
    check_eq("mask_err_pulse", err2, 0);

    k = rand_key();
    run_key(2'b10, k, 0, 0, 5, -1, 128'h0);
    rk_ready = 1'b0;
    for (int w = 0; w < 20 && !rk_valid; w++) @(negedge clk);
    check_eq("valid_before_rst", rk_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rk_ready = 1'b1;
    check_eq("midrst_valid", rk_valid, 0);
    check_eq("midrst_start_ready", start_ready, 1);
    check_eq("midrst_idx", rk_idx, 0);
    check_eq("midrst_data", rk_data, 0);
    check_eq("midrst_last", rk_last, 0);
    repeat (6) @(negedge clk);
    check_eq("midrst_quiet", rk_valid, 0);
    run_key(2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0, 0, -1,
            0, 128'h000102030405060708090a0b0c0d0e0f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
